// File: rtl/dds_freq_est.sv
// dds_freq_est
// Estimates the 32-bit frequency control word of a DDS from its truncated
// 12-bit phase output. The phase steps are summed over a gate of
// 2^GATE_LOG2 clk cycles, and the sum is scaled back up to a 32-bit word.
//
// Parameters
//   GATE_LOG2      log2 of the gate length in clk cycles (1..20)
//
// Ports
//   clk            system clock, rising edge
//   reset_n        synchronous active-low reset
//   start          measurement request, only honoured in IDLE
//   phase_in[11:0] truncated DDS phase, one sample per clk
//   busy           high while measuring or computing
//   est_valid      phase_inc_est holds a completed result
//   est_ready      consumer accepts the result when high with est_valid
//   phase_inc_est  estimated frequency control word
//   alias_err      a phase step >= half a turn was seen in the gate
//                  (present only when DDS_FREQ_EST_ALIAS_EN is defined)
//
// Build option
//   DDS_FREQ_EST_ALIAS_EN  adds the alias_err port and its detection logic.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; last result still visible
// MEASURE | summing phase steps over the gate
// CALC    | scaling the sum into phase_inc_est
// DONE    | result valid, held until est_ready
module dds_freq_est #(
  parameter int GATE_LOG2 = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [11:0] phase_in,
  output logic        busy,
  output logic        est_valid,
  input  logic        est_ready,
  output logic [31:0] phase_inc_est
`ifdef DDS_FREQ_EST_ALIAS_EN
  ,
  output logic        alias_err
`endif
);

  localparam int SUM_W = 12 + GATE_LOG2;
  // One 12-bit step corresponds to 2^20 in the 32-bit word; dividing by the
  // 2^GATE_LOG2 gate leaves a left shift of 20-GATE_LOG2.
  localparam int SHIFT = 20 - GATE_LOG2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    CALC    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [11:0]          prev_phase;
  logic [SUM_W-1:0]     sum;
  logic [GATE_LOG2-1:0] count;
  logic [11:0]          delta;
  logic                 count_last;
  logic [31:0]          sum_ext;
  logic [31:0]          result;

`ifdef DDS_FREQ_EST_ALIAS_EN
  logic alias_seen;
`endif

  // Unsigned wrap-around difference: a phase wrapping through zero still
  // yields the true positive step.
  assign delta      = phase_in - prev_phase;
  // count holds the number of deltas already summed; when it is all-ones
  // the delta summed at this edge is the last one of the gate.
  assign count_last = (count == {GATE_LOG2{1'b1}});
  assign sum_ext    = 32'(sum);
  assign result     = sum_ext << SHIFT;

  assign busy      = (state == MEASURE) || (state == CALC);
  assign est_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (count_last) state_nxt = CALC;
      end
      CALC: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (est_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_phase    <= '0;
      sum           <= '0;
      count         <= '0;
      phase_inc_est <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            prev_phase <= phase_in;
            sum        <= '0;
            count      <= '0;
          end
        end
        MEASURE: begin
          // sum is wide enough for 2^GATE_LOG2 maximal steps, so no overflow.
          sum        <= sum + {{GATE_LOG2{1'b0}}, delta};
          prev_phase <= phase_in;
          count      <= count + 1'b1;
        end
        CALC: begin
          phase_inc_est <= result;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef DDS_FREQ_EST_ALIAS_EN
  // A step of half a turn or more cannot be told apart from a negative
  // step, so any such delta in the gate flags the result as aliased.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      alias_seen <= 1'b0;
      alias_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) alias_seen <= 1'b0;
        end
        MEASURE: begin
          alias_seen <= alias_seen | delta[11];
        end
        CALC: begin
          alias_err <= alias_seen;
        end
        DONE: begin
          if (est_ready) alias_err <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end
`endif

endmodule
